// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM with a memory-ready handshake and a stall watchdog.
// Defining PERF_CNT_EN adds the cycle_cnt/retire_cnt performance counters.
module mips_mc_control #(
  parameter int WAIT_MAX = 15
`ifdef PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       bus_err
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
`endif
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  JUMP   = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11,
    ERR    = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam int WW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          inMem, wdTrip;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Watchdog fires on the WAIT_MAX-th consecutive not-ready cycle; a ready on that cycle still wins.
  always_comb begin
    inMem  = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    wdTrip = (WAIT_MAX != 0) && inMem && !mem_ready && (wait_q == WW'(WAIT_MAX - 1));
    state_d = state_q;
    case (state_q)
      FETCH:  state_d = mem_ready ? DECODE : (wdTrip ? ERR : FETCH);
      DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = EXEC;
          OP_LW, OP_SW:  state_d = MEMADR;
          OP_BEQ:        state_d = BRANCH;
          OP_J:          state_d = JUMP;
          OP_ADDI:       state_d = ADDIEX;
          default:       state_d = ERR;
        endcase
      end
      MEMADR: state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_d = mem_ready ? MEMWB : (wdTrip ? ERR : MEMRD);
      MEMWR:  state_d = mem_ready ? FETCH : (wdTrip ? ERR : MEMWR);
      EXEC:   state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
      MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: state_d = FETCH;
      ERR:    state_d = ERR;
      default: state_d = ERR;
    endcase
    wait_d = (!inMem || mem_ready || (state_d != state_q)) ? '0 : wait_q + WW'(1);
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      MEMWR: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
      end
      MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    // Reset abandons the instruction in flight, so no write strobe may leak out.
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      instr_done  = 1'b0;
    end
  end

  assign state   = state_q;
  assign bus_err = (state_q == ERR);

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycCnt_q, retCnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycCnt_q <= '0;
      retCnt_q <= '0;
    end else if (state_q != ERR) begin
      cycCnt_q <= cycCnt_q + CNT_W'(1);
      if (instr_done) retCnt_q <= retCnt_q + CNT_W'(1);
    end
  end

  assign cycle_cnt  = cycCnt_q;
  assign retire_cnt = retCnt_q;
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
// Table-driven bench for mips_mc_control with a per-cycle expected-output scoreboard.
// Checks the counters as well when PERF_CNT_EN is defined.
module tb_mips_mc_control;

  logic       clk, rst, memReady;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic       instrDone, busErr;
`ifdef PERF_CNT_EN
  logic [31:0] cycleCnt, retireCnt;
  int unsigned cycModel = 0, retModel = 0;
`endif

  mips_mc_control #(.WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(memReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .state(state), .instr_done(instrDone), .bus_err(busErr)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycleCnt), .retire_cnt(retireCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA ALUSrcB ALUOp PCSource instr_done bus_err
  logic [18:0] obs;
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instrDone, busErr};

  localparam logic [18:0] O_RST     = 19'b0_0_0_0_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [18:0] O_FETCH_R = 19'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [18:0] O_FETCH_W = 19'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [18:0] O_DECODE  = 19'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [18:0] O_MEMADR  = 19'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [18:0] O_MEMRD   = 19'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [18:0] O_MEMWR_R = 19'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [18:0] O_MEMWR_W = 19'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [18:0] O_MEMWB   = 19'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [18:0] O_WB_RST  = 19'b0_0_0_0_0_0_1_0_0_0_00_00_00_0_0;
  localparam logic [18:0] O_EXEC    = 19'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [18:0] O_ALUWB   = 19'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [18:0] O_ADDIWB  = 19'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
  localparam logic [18:0] O_BRANCH  = 19'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [18:0] O_JUMP    = 19'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
  localparam logic [18:0] O_ERR     = 19'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [18:0] out;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [18:0] out;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0, bad = 0, vecIdx = 0;

  function automatic vec_t mkVec(logic r, logic [5:0] op, logic mr, logic [3:0] st, logic [18:0] out);
    vec_t v;
    v.rst = r; v.op = op; v.mr = mr; v.st = st; v.out = out;
    return v;
  endfunction

  task automatic addRow(logic r, logic [5:0] op, logic mr, logic [3:0] st, logic [18:0] out);
    vecs.push_back(mkVec(r, op, mr, st, out));
  endtask

  task automatic checkOutput();
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("[TB] FAIL scoreboard empty at vec%0d: got nothing, want one entry", vecIdx);
      return;
    end
    e = sb.pop_front();
    if (state !== e.st) begin
      bad++;
      $display("[TB] FAIL vec%0d state: got %0d want %0d", vecIdx, state, e.st);
    end
    total++;
    if (obs !== e.out) begin
      bad++;
      $display("[TB] FAIL vec%0d outputs (state %0d): got %b want %b", vecIdx, state, obs, e.out);
    end
`ifdef PERF_CNT_EN
    total++;
    if (cycleCnt !== cycModel || retireCnt !== retModel) begin
      bad++;
      $display("[TB] FAIL vec%0d counters: got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
               vecIdx, cycleCnt, retireCnt, cycModel, retModel);
    end
`endif
  endtask

  task automatic applyStimulus(vec_t v);
    exp_t e;
    @(negedge clk);
    rst = v.rst; opcode = v.op; memReady = v.mr;
    e.st = v.st; e.out = v.out;
    sb.push_back(e);
    #2;
    checkOutput();
`ifdef PERF_CNT_EN
    if (v.rst) begin
      cycModel = 0; retModel = 0;
    end else if (v.st != 4'd15) begin
      cycModel++;
      if (v.out[1]) retModel++;
    end
`endif
    vecIdx++;
  endtask

  initial begin
    rst = 1'b1; memReady = 1'b1; opcode = '0;

    addRow(1, LW, 1, 0, O_RST);      addRow(1, LW, 1, 0, O_RST);
    // lw, zero wait
    addRow(0, LW, 1, 0, O_FETCH_R);  addRow(0, LW, 1, 1, O_DECODE);
    addRow(0, LW, 1, 2, O_MEMADR);   addRow(0, LW, 1, 3, O_MEMRD);
    addRow(0, LW, 1, 4, O_MEMWB);
    // sw with three not-ready cycles in MEMWR
    addRow(0, SW, 1, 0, O_FETCH_R);  addRow(0, SW, 1, 1, O_DECODE);
    addRow(0, SW, 1, 2, O_MEMADR);   addRow(0, SW, 0, 5, O_MEMWR_W);
    addRow(0, SW, 0, 5, O_MEMWR_W);  addRow(0, SW, 0, 5, O_MEMWR_W);
    addRow(0, SW, 1, 5, O_MEMWR_R);
    // R-type, beq, j, addi back to back; mem_ready low where it must be ignored
    addRow(0, RT, 1, 0, O_FETCH_R);  addRow(0, RT, 0, 1, O_DECODE);
    addRow(0, RT, 0, 6, O_EXEC);     addRow(0, RT, 0, 7, O_ALUWB);
    addRow(0, BEQ, 1, 0, O_FETCH_R); addRow(0, BEQ, 0, 1, O_DECODE);
    addRow(0, BEQ, 0, 8, O_BRANCH);
    addRow(0, JMP, 1, 0, O_FETCH_R); addRow(0, JMP, 1, 1, O_DECODE);
    addRow(0, JMP, 1, 9, O_JUMP);
    addRow(0, ADDI, 1, 0, O_FETCH_R); addRow(0, ADDI, 1, 1, O_DECODE);
    addRow(0, ADDI, 1, 10, O_MEMADR); addRow(0, ADDI, 1, 11, O_ADDIWB);
    // lw with waits in FETCH and MEMRD
    addRow(0, LW, 0, 0, O_FETCH_W);  addRow(0, LW, 1, 0, O_FETCH_R);
    addRow(0, LW, 1, 1, O_DECODE);   addRow(0, LW, 1, 2, O_MEMADR);
    addRow(0, LW, 0, 3, O_MEMRD);    addRow(0, LW, 1, 3, O_MEMRD);
    addRow(0, LW, 1, 4, O_MEMWB);
    // illegal opcode traps until reset
    addRow(0, BAD, 1, 0, O_FETCH_R); addRow(0, BAD, 1, 1, O_DECODE);
    addRow(0, BAD, 1, 15, O_ERR);    addRow(0, BAD, 0, 15, O_ERR);
    addRow(0, RT, 1, 15, O_ERR);     addRow(1, RT, 1, 15, O_ERR);
    addRow(1, RT, 1, 0, O_RST);
    // reset while in MEMWB suppresses the register write
    addRow(0, LW, 1, 0, O_FETCH_R);  addRow(0, LW, 1, 1, O_DECODE);
    addRow(0, LW, 1, 2, O_MEMADR);   addRow(0, LW, 1, 3, O_MEMRD);
    addRow(1, LW, 1, 4, O_WB_RST);   addRow(1, LW, 1, 0, O_RST);

    @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Watchdog: 15 not-ready FETCH cycles end in ERR
    for (int i = 0; i < 15; i++) applyStimulus(mkVec(0, RT, 0, 0, O_FETCH_W));
    applyStimulus(mkVec(0, RT, 0, 15, O_ERR));
    applyStimulus(mkVec(1, RT, 1, 15, O_ERR));
    applyStimulus(mkVec(1, RT, 1, 0, O_RST));

    // Ready on the 15th cycle wins over the watchdog
    for (int i = 0; i < 14; i++) applyStimulus(mkVec(0, RT, 0, 0, O_FETCH_W));
    applyStimulus(mkVec(0, RT, 1, 0, O_FETCH_R));
    applyStimulus(mkVec(0, RT, 1, 1, O_DECODE));
    applyStimulus(mkVec(0, RT, 1, 6, O_EXEC));
    applyStimulus(mkVec(0, RT, 1, 7, O_ALUWB));

    // Watchdog inside MEMRD, counting from entry
    applyStimulus(mkVec(0, LW, 1, 0, O_FETCH_R));
    applyStimulus(mkVec(0, LW, 0, 1, O_DECODE));
    applyStimulus(mkVec(0, LW, 0, 2, O_MEMADR));
    for (int i = 0; i < 15; i++) applyStimulus(mkVec(0, LW, 0, 3, O_MEMRD));
    applyStimulus(mkVec(0, LW, 0, 15, O_ERR));
    applyStimulus(mkVec(1, LW, 1, 15, O_ERR));
    applyStimulus(mkVec(1, LW, 1, 0, O_RST));

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard drain: got %0d leftover entries, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multi-cycle control FSM for the next-generation MIPS core; replaces the single-cycle combinational control decode.
- One instruction spans 3–5 states. Datapath registers (IR, MDR, A, B, ALUOut) are shared across cycles.
- Memory accesses use a ready handshake, so the core can run against wait-stated memory.
- A watchdog traps stalled memory accesses.

Parameters:
- WAIT_MAX, 15: maximum consecutive not-ready cycles tolerated in a memory state; 0 disables the watchdog.
- CNT_W, 32: width of the performance counters (only with PERF_CNT_EN).

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by ALU zero (beq)
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  load IR from memory data
- MemtoReg  out  1  register write data: 0=ALUOut, 1=MDR
- RegDst  out  1  destination register: 0=rt, 1=rd
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A operand: 0=PC, 1=A
- ALUSrcB  out  2  ALU B operand: 00=B, 01=4, 10=signext, 11=signext<<2
- ALUOp  out  2  to ALU control: 00=add, 01=sub, 10=funct
- PCSource  out  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
- state  out  4  current state encoding (debug)
- instr_done  out  1  1-cycle pulse on instruction retirement
- bus_err  out  1  sticky; set when the FSM is in ERR
- cycle_cnt  out  CNT_W  only with PERF_CNT_EN
- retire_cnt  out  CNT_W  only with PERF_CNT_EN

Behaviour:
- Reset
  - rst=1 at a rising edge: state<=FETCH(0), wait_cnt<=0, bus_err<=0.
  - While rst=1, all strobes are forced 0: PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, instr_done.
  - Reset mid-instruction abandons it; no partial register write occurs after the reset edge.
- States (4-bit encoding):
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, ERR=15.
- Outputs are Moore-decoded from state; any output not listed for a state is 0.
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: IorD=1, MemRead=1.
  - MEMWR: IorD=1, MemWrite=1, instr_done=mem_ready.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - ALUWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1.
  - ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1.
  - JUMP: PCWrite=1, PCSource=10, instr_done=1.
  - ERR: all strobes 0, bus_err=1.
- Transitions:
  - FETCH -> DECODE when mem_ready, else hold.
  - DECODE, by opcode:
    - 000000 -> EXEC
    - 100011 or 101011 -> MEMADR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDIEX
    - any other opcode -> ERR (illegal instruction)
  - MEMADR -> MEMRD for lw, MEMWR for sw.
  - MEMRD -> MEMWB when mem_ready, else hold.
  - MEMWR -> FETCH when mem_ready, else hold.
  - EXEC -> ALUWB; ADDIEX -> ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
  - ERR -> ERR until rst.
- Latency with zero-wait memory, FETCH to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each not-ready cycle adds 1.
- Watchdog:
  - Applies in FETCH, MEMRD and MEMWR only.
  - wait_cnt clears on entry to a memory state and whenever mem_ready=1, and increments on each mem_ready=0 cycle.
  - If mem_ready=0 and wait_cnt==WAIT_MAX-1 (i.e. the WAIT_MAX-th consecutive not-ready cycle), next state=ERR.
  - mem_ready=1 on that same cycle wins: normal transition, no ERR.
  - WAIT_MAX=0 disables the watchdog; states hold indefinitely.
- mem_ready is ignored outside memory states.

Optional Feature:
- PERF_CNT_EN defined:
  - cycle_cnt increments every non-reset cycle.
  - retire_cnt increments on each instr_done.
  - Both clear on rst, wrap modulo 2^CNT_W, and freeze while in ERR.
- PERF_CNT_EN undefined: both ports, the counters and CNT_W usage are absent. FSM timing is identical.

Test Plan:
- rst=1 for 2 cycles, then release, mem_ready=1 -> state=0 and all strobes 0 during reset; first post-reset cycle has MemRead=1, PCWrite=1, IRWrite=1.
- lw (opcode 100011), mem_ready=1 -> state sequence 0,1,2,3,4,0; RegWrite=1 with MemtoReg=1 only in state 4; instr_done pulses once; retire_cnt=1, cycle_cnt=5.
- sw with mem_ready low for 3 cycles in MEMWR -> MemWrite held for 4 cycles, instr_done on the 4th, FETCH follows; total 7 cycles.
- R-type, beq, j, addi back-to-back, zero-wait -> 4+3+3+4=14 cycles; PCWriteCond=1 only in BRANCH; PCSource=10 in JUMP; RegDst=1 only in ALUWB.
- Opcode 111111 -> DECODE then ERR; bus_err=1 and state=15 until rst; no strobes asserted.
- WAIT_MAX=15, mem_ready=0 in FETCH -> ERR after exactly 15 cycles. Repeat with mem_ready=1 on the 15th cycle -> DECODE, no error.
